// File: rtl/adder_pkg.sv
// Shared types and default widths for the adder compute stage.
package adder_pkg;

    localparam int ADDER_BITS_DEF     = 8;
    localparam int HOST_DATA_BITS_DEF = 32;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        HAVE_A = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/adder_core.sv
// Combinational adder: sum and carry-out of two operands.
// With ADDER_SATURATE_EN defined, an overflowing sum is clamped to all-ones.
module adder_core
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_BITS_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[WIDTH];

`ifdef ADDER_SATURATE_EN
    assign o_sum = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
    assign o_sum = w_full[WIDTH-1:0];
`endif

endmodule

// File: rtl/adder_unit.sv
// Operand-ordered adder stage downstream of the MMU, with protocol error flag
// and host-readable event counters. Optional clamping via ADDER_SATURATE_EN.
module adder_unit
    import adder_pkg::*;
#(
    parameter int ADDER_BITS     = ADDER_BITS_DEF,
    parameter int HOST_DATA_BITS = HOST_DATA_BITS_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      a_valid,
    input  logic [ADDER_BITS-1:0]     a_data,
    input  logic                      b_valid,
    input  logic [ADDER_BITS-1:0]     b_data,
    output logic                      c_valid,
    output logic [ADDER_BITS-1:0]     c_data,
    output logic                      ovf,
    output logic                      err,
    output logic [HOST_DATA_BITS-1:0] ops_count,
    output logic [HOST_DATA_BITS-1:0] ovf_count
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [ADDER_BITS-1:0]     r_a;
    logic [ADDER_BITS-1:0]     r_c;
    logic                      r_ovf;
    logic                      r_err;
    logic [HOST_DATA_BITS-1:0] r_ops;
    logic [HOST_DATA_BITS-1:0] r_ovfc;

    logic                      w_load_a;
    logic                      w_do_result;
    logic                      w_set_err;
    logic [ADDER_BITS-1:0]     w_sum;
    logic                      w_carry;

    localparam logic [HOST_DATA_BITS-1:0] L_CNT_ONE = {{(HOST_DATA_BITS-1){1'b0}}, 1'b1};

    adder_core #(
        .WIDTH (ADDER_BITS)
    ) u_core (
        .i_a     (r_a),
        .i_b     (b_data),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_do_result  = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            // RESULT behaves like WAIT_A apart from the one-cycle c_valid pulse.
            WAIT_A, RESULT: begin
                w_state_next = WAIT_A;
                if (a_valid) begin
                    w_load_a     = 1'b1;
                    w_state_next = HAVE_A;
                end
                if (b_valid) begin
                    w_set_err = 1'b1;
                end
            end
            HAVE_A: begin
                if (b_valid) begin
                    w_do_result  = 1'b1;
                    w_state_next = RESULT;
                    w_set_err    = a_valid;
                end else if (a_valid) begin
                    w_load_a  = 1'b1;
                    w_set_err = 1'b1;
                end
            end
            default: begin
                w_state_next = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_ops   <= '0;
            r_ovfc  <= '0;
        end else if (clear) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_ops   <= '0;
            r_ovfc  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_a) begin
                r_a <= a_data;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_do_result) begin
                r_c   <= w_sum;
                r_ovf <= w_carry;
                r_ops <= r_ops + L_CNT_ONE;
                // Overflow counter sticks at all-ones rather than wrapping.
                if (w_carry && (r_ovfc != {HOST_DATA_BITS{1'b1}})) begin
                    r_ovfc <= r_ovfc + L_CNT_ONE;
                end
            end
        end
    end

    assign c_valid   = (r_state == RESULT);
    assign c_data    = r_c;
    assign ovf       = r_ovf;
    assign err       = r_err;
    assign ops_count = r_ops;
    assign ovf_count = r_ovfc;

endmodule
